// File: rtl/itch_msg_scheduler.sv
// ITCH message scheduler: steers parser payload bytes to the A/D/X/E decoder by type byte.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; every valid byte is consumed, and idle cycles leave all state unchanged.
module itch_msg_scheduler #(
    parameter int LEN_A = 36,
    parameter int LEN_D = 19,
    parameter int LEN_X = 23,
    parameter int LEN_E = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  payload_in,
    input  logic        payload_valid_in,
    input  logic        start_flag,
    output logic [7:0]  dec_payload_out,
    output logic [3:0]  dec_valid_out,
    output logic [3:0]  dec_start_out,
    output logic        msg_done,
    output logic        unknown_type,
    output logic        trunc_err,
    output logic [15:0] msg_count,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {IDLE, ROUTE, SKIP} state_t;

    localparam logic [5:0] LEN_A_W = LEN_A[5:0];
    localparam logic [5:0] LEN_D_W = LEN_D[5:0];
    localparam logic [5:0] LEN_X_W = LEN_X[5:0];
    localparam logic [5:0] LEN_E_W = LEN_E[5:0];

    state_t      state, state_nxt;
    logic [5:0]  byte_cnt, byte_cnt_nxt;
    logic [1:0]  sel, sel_nxt;
    logic [5:0]  cur_len;
    logic        type_known;
    logic [1:0]  type_sel;
    logic [3:0]  valid_nxt, start_nxt;
    logic        pay_upd, done_nxt, unk_nxt, trunc_nxt;
    logic [8:0]  err_sum;

    always_comb begin
        type_known = 1'b1;
        type_sel   = 2'd0;
        case (payload_in)
            8'h41:   type_sel = 2'd0;
            8'h44:   type_sel = 2'd1;
            8'h58:   type_sel = 2'd2;
            8'h45:   type_sel = 2'd3;
            default: type_known = 1'b0;
        endcase
    end

    always_comb begin
        cur_len = LEN_A_W;
        case (sel)
            2'd0: cur_len = LEN_A_W;
            2'd1: cur_len = LEN_D_W;
            2'd2: cur_len = LEN_X_W;
            2'd3: cur_len = LEN_E_W;
            default: cur_len = LEN_A_W;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        sel_nxt      = sel;
        valid_nxt    = 4'b0000;
        start_nxt    = 4'b0000;
        pay_upd      = 1'b0;
        done_nxt     = 1'b0;
        unk_nxt      = 1'b0;
        trunc_nxt    = 1'b0;
        if (payload_valid_in) begin
            if (start_flag) begin
                // A new type byte always wins; an open message is abandoned as truncated.
                trunc_nxt = (state == ROUTE);
                if (type_known) begin
                    state_nxt    = ROUTE;
                    sel_nxt      = type_sel;
                    byte_cnt_nxt = 6'd1;
                    valid_nxt    = 4'b0001 << type_sel;
                    start_nxt    = 4'b0001 << type_sel;
                    pay_upd      = 1'b1;
                end else begin
                    state_nxt    = SKIP;
                    byte_cnt_nxt = 6'd0;
                    unk_nxt      = 1'b1;
                end
            end else if (state == ROUTE) begin
                valid_nxt    = 4'b0001 << sel;
                pay_upd      = 1'b1;
                byte_cnt_nxt = byte_cnt + 6'd1;
                if (byte_cnt == cur_len - 6'd1) begin
                    done_nxt     = 1'b1;
                    state_nxt    = IDLE;
                    byte_cnt_nxt = 6'd0;
                end
            end
        end
    end

    assign err_sum = {1'b0, err_count} + {8'd0, unk_nxt} + {8'd0, trunc_nxt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            byte_cnt        <= 6'd0;
            sel             <= 2'd0;
            dec_payload_out <= 8'h00;
            dec_valid_out   <= 4'b0000;
            dec_start_out   <= 4'b0000;
            msg_done        <= 1'b0;
            unknown_type    <= 1'b0;
            trunc_err       <= 1'b0;
            msg_count       <= 16'd0;
            err_count       <= 8'd0;
        end else begin
            state         <= state_nxt;
            byte_cnt      <= byte_cnt_nxt;
            sel           <= sel_nxt;
            dec_valid_out <= valid_nxt;
            dec_start_out <= start_nxt;
            msg_done      <= done_nxt;
            unknown_type  <= unk_nxt;
            trunc_err     <= trunc_nxt;
            if (pay_upd) begin
                dec_payload_out <= payload_in;
            end
            if (done_nxt) begin
                msg_count <= msg_count + 16'd1;
            end
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: doc/itch_msg_scheduler.md
ITCH_MSG_SCHEDULER -- requirements
Module: itch_msg_scheduler

Interface
REQ-001 Parameter: LEN_A, 36, total Add Order message length in bytes, type byte included.
REQ-002 Parameter: LEN_D, 19, total Order Delete message length in bytes.
REQ-003 Parameter: LEN_X, 23, total Order Cancel message length in bytes.
REQ-004 Parameter: LEN_E, 31, total Order Executed message length in bytes.
REQ-005 Each LEN_* SHALL be in the range 2..63; other values are unsupported.
REQ-006 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-007 Port: rst  input  1  reset, asynchronous, active-high.
REQ-008 Port: payload_in  input  8  payload byte from the header parser.
REQ-009 Port: payload_valid_in  input  1  payload_in is valid this cycle.
REQ-010 Port: start_flag  input  1  with payload_valid_in, marks the message type byte (byte 0).
REQ-011 Port: dec_payload_out  output  8  registered byte routed to the selected decoder.
REQ-012 Port: dec_valid_out  output  4  one-hot byte valid; bit 0='A', 1='D', 2='X', 3='E'.
REQ-013 Port: dec_start_out  output  4  one-hot start pulse, high with the type byte only.
REQ-014 Port: msg_done  output  1  one-cycle pulse, high with the last routed byte of a message.
REQ-015 Port: unknown_type  output  1  one-cycle pulse when an unsupported type byte is seen.
REQ-016 Port: trunc_err  output  1  one-cycle pulse when a message is cut short by a new start_flag.
REQ-017 Port: msg_count  output  16  count of completed messages; wraps at 65535 to 0.
REQ-018 Port: err_count  output  8  count of unknown_type plus trunc_err events; saturates at 255.

Function
REQ-019 The block SHALL be an FSM with states IDLE, ROUTE and SKIP, plus a 6-bit byte_cnt and a 2-bit sel register.
REQ-020 All outputs SHALL be registered, with exactly 1 cycle of latency from the input byte.
REQ-021 Accept: a cycle with payload_valid_in=1; cycles with payload_valid_in=0 are gaps that change no state and drive all valid and pulse outputs low.
REQ-022 IDLE + accept + start_flag + known type ('A' 0x41, 'D' 0x44, 'X' 0x58, 'E' 0x45) -> set sel, byte_cnt=1, go to ROUTE; next cycle dec_start_out[sel]=1, dec_valid_out[sel]=1, dec_payload_out=type byte.
REQ-023 IDLE + accept + start_flag + any other type -> go to SKIP; next cycle unknown_type=1 and err_count increments; nothing is routed.
REQ-024 IDLE + accept without start_flag -> the byte is discarded with no output.
REQ-025 ROUTE + accept without start_flag -> forward the byte on dec_valid_out[sel] and increment byte_cnt; if byte_cnt==LEN(sel)-1, assert msg_done with that byte, increment msg_count and return to IDLE.
REQ-026 ROUTE + accept + start_flag (any byte_cnt) -> trunc_err=1 and err_count increments next cycle, no msg_done, and the byte is processed as in REQ-022/REQ-023 in the same cycle. Two messages never overlap.
REQ-027 SKIP + accept without start_flag -> discard; SKIP + accept + start_flag -> process as in REQ-022/REQ-023 with no trunc_err.
REQ-028 dec_valid_out and dec_start_out SHALL be one-hot or zero; dec_payload_out SHALL hold its value when no valid is asserted.
REQ-029 A single cycle that raises both trunc_err and unknown_type SHALL increment err_count by 2, saturating at 255.
REQ-030 msg_done SHALL never coincide with dec_start_out.

Reset
REQ-031 While rst=1: state=IDLE, byte_cnt=0, sel=0, dec_payload_out=0x00, dec_valid_out=0, dec_start_out=0, msg_done=0, unknown_type=0, trunc_err=0, msg_count=0, err_count=0.
REQ-032 rst asserted mid-message SHALL abandon the message with no msg_done or trunc_err; after release the block waits in IDLE for the next start_flag.

Verification
REQ-033 Add Order: 36 contiguous bytes, first byte 0x41 with start_flag -> dec_start_out=0001 for 1 cycle, 36 cycles of dec_valid_out=0001, msg_done on the 36th routed byte, msg_count=1.
REQ-034 Delete with gaps: 19 bytes of 'D' with a gap after every byte -> 19 routed bytes on bit 1, outputs idle during gaps, msg_done with the 19th byte.
REQ-035 Truncation: 'X' message, start_flag+'E' arriving at byte 10 -> trunc_err=1 coincident with dec_start_out=1000, err_count=1, the 'E' message then completes after 31 bytes.
REQ-036 Unknown: type 0x53 ('S') followed by 10 bytes, then a valid 'A' message -> unknown_type=1, no valid outputs for the 'S' bytes, the 'A' message routes normally.
REQ-037 Reset mid-message: rst asserted at byte 20 of 'A' -> all outputs 0; non-start bytes afterwards are ignored; next 'A' completes with msg_count=1 counted from reset.
REQ-038 Counter limits: 256 unknown types -> err_count stays at 255; 65536 completed 'D' messages -> msg_count wraps to 0.
